mux_scan_controller: RTL and testbench

Sequencer that sits directly upstream of the 16:1 single-bit multiplexer. It drives the multiplexer's 4-bit select, steps through a programmed channel range, and samples the multiplexer's output once per channel. The sampled bits are assembled into a 16-bit frame, which is delivered downstream over a valid/ready handshake. This turns the combinational mux into a periodic parallel-capture path for status or sensor bits.

---
 rtl/mux_scan_controller.sv | 161 ++++++++++++++++
 tb/tb_mux_scan_controller.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_controller.sv
// -----------------------------------------------------------------------------
// mux_scan_controller
//
// Sequencer placed upstream of an N_CH:1 single-bit multiplexer. It walks the
// mux select through a programmed channel range (wrapping past the top
// channel), samples the mux output once per channel after a settle delay, and
// delivers the assembled frame downstream over a valid/ready handshake.
//
// Parameters:
//   N_CH   - number of mux channels and frame width (must equal 2**SEL_W)
//   SEL_W  - select width
//   SETTLE - settle cycles between a select change and its sample (0..7)
//
// Ports:
//   clk           in   clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   start         in   level request to begin a scan
//   first_ch      in   first channel of the scan (latched on accept)
//   last_ch       in   last channel of the scan (latched on accept)
//   sel           out  registered mux select
//   mux_out       in   mux output, sampled in SAMPLE
//   busy          out  high whenever the sequencer is not idle
//   start_dropped out  one-cycle pulse per cycle start is seen while busy
//   frame         out  captured frame, bit i = channel i
//   frame_valid   out  frame holding register is full
//   frame_ready   in   consumer accepts the frame
// -----------------------------------------------------------------------------
module mux_scan_controller #(
  parameter int N_CH   = 16,
  parameter int SEL_W  = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SEL_W-1:0] first_ch,
  input  logic [SEL_W-1:0] last_ch,
  output logic [SEL_W-1:0] sel,
  input  logic             mux_out,
  output logic             busy,
  output logic             start_dropped,
  output logic [N_CH-1:0]  frame,
  output logic             frame_valid,
  input  logic             frame_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  // State entered whenever a new select value is applied (accept or advance).
  localparam state_t     ENTRY_STATE = (SETTLE > 0) ? S_SETTLE : S_SAMPLE;
  localparam logic [2:0] CNT_INIT    = (SETTLE > 0) ? 3'(SETTLE - 1) : 3'd0;

  state_t           r_state, w_next_state;
  logic [SEL_W-1:0] r_sel, w_sel;
  logic [SEL_W-1:0] r_last, w_last;
  logic [2:0]       r_cnt, w_cnt;
  logic [N_CH-1:0]  r_shadow, w_shadow;
  logic [N_CH-1:0]  r_frame, w_frame;
  logic             r_frame_valid, w_frame_valid;
  logic             r_busy, w_busy;
  logic             r_start_dropped, w_start_dropped;

  // NOTE: sequential state uses non-blocking assignments only; every register,
  // including the shadow frame, gets a reset value so an aborted scan leaves
  // nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_sel           <= '0;
      r_last          <= '0;
      r_cnt           <= '0;
      r_shadow        <= '0;
      r_frame         <= '0;
      r_frame_valid   <= 1'b0;
      r_busy          <= 1'b0;
      r_start_dropped <= 1'b0;
    end else begin
      r_state         <= w_next_state;
      r_sel           <= w_sel;
      r_last          <= w_last;
      r_cnt           <= w_cnt;
      r_shadow        <= w_shadow;
      r_frame         <= w_frame;
      r_frame_valid   <= w_frame_valid;
      r_busy          <= w_busy;
      r_start_dropped <= w_start_dropped;
    end
  end

  // NOTE: every signal written here gets a hold/default value first, so no
  // path through the case statement can infer a latch.
  always_comb begin
    w_next_state  = r_state;
    w_sel         = r_sel;
    w_last        = r_last;
    w_cnt         = r_cnt;
    w_shadow      = r_shadow;
    w_frame       = r_frame;
    w_frame_valid = r_frame_valid;

    // Consumer takes the frame; a reload from DONE below overrides this.
    if (r_frame_valid && frame_ready) begin
      w_frame_valid = 1'b0;
    end

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_last       = last_ch;
          w_sel        = first_ch;
          w_shadow     = '0;
          w_cnt        = CNT_INIT;
          w_next_state = ENTRY_STATE;
        end
      end
      S_SETTLE: begin
        if (r_cnt == 3'd0) begin
          w_next_state = S_SAMPLE;
        end else begin
          w_cnt = r_cnt - 3'd1;
        end
      end
      S_SAMPLE: begin
        w_shadow[r_sel] = mux_out;
        if (r_sel == r_last) begin
          w_next_state = S_DONE;
        end else begin
          // Select width matches the channel count, so this wraps top -> 0.
          w_sel        = r_sel + SEL_W'(1);
          w_cnt        = CNT_INIT;
          w_next_state = ENTRY_STATE;
        end
      end
      S_DONE: begin
        if (!r_frame_valid || frame_ready) begin
          w_frame       = r_shadow;
          w_frame_valid = 1'b1;
          w_next_state  = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase

    // Registered decodes: busy tracks the state, drops flag a start seen while
    // the sequencer was busy in the current cycle.
    w_busy          = (w_next_state != S_IDLE);
    w_start_dropped = start && r_busy;
  end

  assign sel           = r_sel;
  assign busy          = r_busy;
  assign start_dropped = r_start_dropped;
  assign frame         = r_frame;
  assign frame_valid   = r_frame_valid;

endmodule

// File: tb/tb_mux_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_controller
//
// Directed bench for mux_scan_controller. One instance uses the default
// SETTLE=1, a second uses SETTLE=0. Each instance is fed by a behavioural
// 16:1 mux over a shared input word.
// -----------------------------------------------------------------------------
module tb_mux_scan_controller;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_bits;

  // SETTLE=1 instance
  logic        start;
  logic [3:0]  first_ch, last_ch, sel;
  logic        mux_out, busy, start_dropped, frame_valid, frame_ready;
  logic [15:0] frame;

  // SETTLE=0 instance
  logic        start0;
  logic [3:0]  first0, last0, sel0;
  logic        mux_out0, busy0, start_dropped0, frame_valid0, frame_ready0;
  logic [15:0] frame0;

  int checks = 0;
  int errors = 0;

  mux_scan_controller #(.N_CH(16), .SEL_W(4), .SETTLE(1)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .first_ch      (first_ch),
    .last_ch       (last_ch),
    .sel           (sel),
    .mux_out       (mux_out),
    .busy          (busy),
    .start_dropped (start_dropped),
    .frame         (frame),
    .frame_valid   (frame_valid),
    .frame_ready   (frame_ready)
  );

  mux_scan_controller #(.N_CH(16), .SEL_W(4), .SETTLE(0)) u_dut0 (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start0),
    .first_ch      (first0),
    .last_ch       (last0),
    .sel           (sel0),
    .mux_out       (mux_out0),
    .busy          (busy0),
    .start_dropped (start_dropped0),
    .frame         (frame0),
    .frame_valid   (frame_valid0),
    .frame_ready   (frame_ready0)
  );

  // Behavioural multiplexers
  assign mux_out  = in_bits[sel];
  assign mux_out0 = in_bits[sel0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Advance one rising edge, then step off it before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_sel;
    int drops;
    int valid_seen;

    rst_n        = 1'b0;
    in_bits      = 16'h0000;
    start        = 1'b0;
    first_ch     = 4'd0;
    last_ch      = 4'd0;
    frame_ready  = 1'b1;
    start0       = 1'b0;
    first0       = 4'd0;
    last0        = 4'd0;
    frame_ready0 = 1'b1;

    // ---------------- Reset state ----------------
    #3;
    check("rst_sel",     sel,           0);
    check("rst_busy",    busy,          0);
    check("rst_frame",   frame,         0);
    check("rst_valid",   frame_valid,   0);
    check("rst_dropped", start_dropped, 0);
    #9 rst_n = 1'b1;

    // ---------------- Full scan, defaults ----------------
    in_bits  = 16'hA5C3;
    first_ch = 4'd0;
    last_ch  = 4'd15;
    start    = 1'b1;
    tick();                      // E0
    start = 1'b0;
    check("full_busy_e0", busy, 1);
    check("full_sel_e0",  sel,  0);
    for (int n = 1; n <= 33; n++) begin
      tick();
      if (n < 33) begin
        exp_sel = (n / 2 > 15) ? 15 : n / 2;
        check($sformatf("full_sel_e%0d", n), sel, exp_sel);
        check($sformatf("full_valid_e%0d", n), frame_valid, 0);
      end
    end
    check("full_valid_33", frame_valid, 1);
    check("full_frame",    frame,       16'hA5C3);
    check("full_busy_33",  busy,        0);
    tick();
    check("full_valid_34", frame_valid, 0);

    // ---------------- Wrapped partial range ----------------
    in_bits  = 16'hFFFF;
    first_ch = 4'd14;
    last_ch  = 4'd1;
    start    = 1'b1;
    tick();                      // E0
    start = 1'b0;
    check("wrap_sel_e0", sel, 14);
    tick(); tick();
    check("wrap_sel_e2", sel, 15);
    tick(); tick();
    check("wrap_sel_e4", sel, 0);
    tick(); tick();
    check("wrap_sel_e6", sel, 1);
    tick(); tick();
    check("wrap_valid_e8", frame_valid, 0);
    tick();
    check("wrap_valid_e9", frame_valid, 1);
    check("wrap_frame",    frame,       16'hC003);
    tick();
    check("wrap_valid_e10", frame_valid, 0);

    // ---------------- Backpressure ----------------
    frame_ready = 1'b0;
    in_bits     = 16'h0001;
    first_ch    = 4'd0;
    last_ch     = 4'd1;
    start       = 1'b1;
    tick();                      // E0 of first scan
    start = 1'b0;
    repeat (4) tick();
    check("bp_valid_pre", frame_valid, 0);
    tick();                      // E0+5
    check("bp_valid_1", frame_valid, 1);
    check("bp_frame_1", frame,       16'h0001);
    in_bits = 16'h0002;
    start   = 1'b1;
    tick();                      // E0 of second scan
    start = 1'b0;
    repeat (10) tick();
    check("bp_stall_frame", frame,       16'h0001);
    check("bp_stall_valid", frame_valid, 1);
    check("bp_stall_busy",  busy,        1);
    frame_ready = 1'b1;
    tick();
    check("bp_reload_frame", frame,       16'h0002);
    check("bp_reload_valid", frame_valid, 1);
    check("bp_reload_busy",  busy,        0);
    tick();
    check("bp_drain_valid", frame_valid, 0);

    // ---------------- Dropped start ----------------
    in_bits  = 16'h3C3A;
    first_ch = 4'd0;
    last_ch  = 4'd3;
    start    = 1'b1;
    tick();                      // E0
    start = 1'b0;
    tick(); tick();              // E0+2
    check("drop_sel_e2", sel, 1);
    start    = 1'b1;
    first_ch = 4'd8;
    last_ch  = 4'd9;
    drops    = 0;
    for (int n = 3; n <= 9; n++) begin
      tick();
      if (start_dropped) drops++;
      if (n == 5) start = 1'b0;
      if (n == 6) check("drop_sel_e6", sel, 3);
    end
    check("drop_count", drops,       3);
    check("drop_valid", frame_valid, 1);
    check("drop_frame", frame,       16'h000A);
    tick();
    check("drop_busy_after", busy, 0);

    // ---------------- Reset mid-scan ----------------
    in_bits  = 16'hFFFF;
    first_ch = 4'd0;
    last_ch  = 4'd15;
    start    = 1'b1;
    tick();                      // E0
    start = 1'b0;
    repeat (14) tick();          // E0+14
    check("mrst_sel_pre", sel, 7);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_sel",   sel,         0);
    check("mrst_busy",  busy,        0);
    check("mrst_valid", frame_valid, 0);
    check("mrst_frame", frame,       0);
    tick(); tick();
    #2 rst_n = 1'b1;
    valid_seen = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (frame_valid || busy) valid_seen++;
    end
    check("mrst_no_frame", valid_seen, 0);

    // ---------------- SETTLE=0, single channel ----------------
    in_bits = 16'hFFFF;
    first0  = 4'd9;
    last0   = 4'd9;
    start0  = 1'b1;
    tick();                      // E0
    start0 = 1'b0;
    check("s0_busy_e0",  busy0,        1);
    check("s0_sel_e0",   sel0,         9);
    check("s0_valid_e0", frame_valid0, 0);
    tick();
    check("s0_valid_e1", frame_valid0, 0);
    tick();
    check("s0_valid_e2", frame_valid0, 1);
    check("s0_frame",    frame0,       16'h0200);
    check("s0_busy_e2",  busy0,        0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
